// File: rtl/spi_coeff_loader_if.sv
// rtl/spi_coeff_loader_if.sv - request, coefficient and SPI pins of the coefficient loader
interface spi_coeff_loader_if #(
    parameter int COEFF_WIDTH = 8,
    parameter int NUM_COEFFS  = 5
) ();
    logic                              start;
    logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeffs;
    logic                              busy;
    logic                              done;
    logic                              cs;
    logic                              spiClk;
    logic                              mosi;

    modport master (
        input  start,
        input  coeffs,
        output busy,
        output done,
        output cs,
        output spiClk,
        output mosi
    );

    modport slave (
        output start,
        output coeffs,
        input  busy,
        input  done,
        input  cs,
        input  spiClk,
        input  mosi
    );
endinterface

// File: rtl/spi_coeff_loader.sv
// rtl/spi_coeff_loader.sv - SPI mode-0 master shifting a latched coefficient set out in one cs frame
module spi_coeff_loader #(
    parameter int COEFF_WIDTH = 8,
    parameter int NUM_COEFFS  = 5,
    parameter int CLK_DIV     = 4
) (
    input  logic                clk,
    input  logic                reset,
    spi_coeff_loader_if.master  bus
);
    localparam int B  = NUM_COEFFS * COEFF_WIDTH;
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(B + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(B - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} stateT;

    stateT          state;
    logic [HW-1:0]  halfCnt;
    logic [BW-1:0]  bitCnt;
    logic [B-1:0]   shiftReg;
    logic [B-1:0]   loadWord;
    logic           csReg;
    logic           spiClkReg;
    logic           busyReg;
    logic           doneReg;
    logic           halfLast;

    // coeff[0] lands in the top bits so it leaves first
    always_comb begin
        loadWord = '0;
        for (int i = 0; i < NUM_COEFFS; i++) begin
            loadWord[B-1-i*COEFF_WIDTH -: COEFF_WIDTH] = bus.coeffs[i*COEFF_WIDTH +: COEFF_WIDTH];
        end
    end

    assign halfLast = (halfCnt == HALF_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            halfCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            csReg     <= 1'b1;
            spiClkReg <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shiftReg <= loadWord;
                        halfCnt  <= '0;
                        bitCnt   <= '0;
                        csReg    <= 1'b0;
                        busyReg  <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (halfLast) begin
                        halfCnt   <= '0;
                        spiClkReg <= 1'b1;
                        state     <= HIGH;
                    end else begin
                        halfCnt <= halfCnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (halfLast) begin
                        // zero fill: after the final shift the register is empty, so mosi idles low
                        halfCnt   <= '0;
                        spiClkReg <= 1'b0;
                        shiftReg  <= shiftReg << 1;
                        state     <= (bitCnt < BIT_LAST) ? LOW : HOLD;
                    end else begin
                        halfCnt <= halfCnt + 1'b1;
                    end
                end
                LOW: begin
                    if (halfLast) begin
                        halfCnt   <= '0;
                        bitCnt    <= bitCnt + 1'b1;
                        spiClkReg <= 1'b1;
                        state     <= HIGH;
                    end else begin
                        halfCnt <= halfCnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (halfLast) begin
                        halfCnt <= '0;
                        csReg   <= 1'b1;
                        doneReg <= 1'b1;
                        state   <= GAP;
                    end else begin
                        halfCnt <= halfCnt + 1'b1;
                    end
                end
                GAP: begin
                    if (halfLast) begin
                        halfCnt <= '0;
                        busyReg <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        halfCnt <= halfCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cs     = csReg;
    assign bus.spiClk = spiClkReg;
    assign bus.mosi   = shiftReg[B-1];
    assign bus.busy   = busyReg;
    assign bus.done   = doneReg;
endmodule

// File: tb/tb_spi_coeff_loader.sv
// tb/tb_spi_coeff_loader.sv - self-checking bench for spi_coeff_loader with cycle model and SPI slave
module tb_spi_coeff_loader;
    localparam int W = 8;
    localparam int N = 5;
    localparam int D = 2;
    localparam int B = N * W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_coeff_loader_if #(.COEFF_WIDTH(W), .NUM_COEFFS(N)) bus ();

    spi_coeff_loader #(.COEFF_WIDTH(W), .NUM_COEFFS(N), .CLK_DIV(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit checkEn    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: one frame per accepted start, outputs derived from position k within the frame
    bit           mActive = 1'b0;
    int           mT0     = 0;
    logic [B-1:0] mCoeffs = '0;
    logic [B-1:0] expQ[$];

    function automatic logic [4:0] expOut(input bit active, input int k, input logic [B-1:0] cf);
        logic cs, sc, mo, bz, dn;
        int   j, m, lowEnd;
        cs = 1'b1; sc = 1'b0; mo = 1'b0; bz = 1'b0; dn = 1'b0;
        lowEnd = D * (1 + 2 * B);
        if (active && k >= 1 && k <= D * (2 + 2 * B)) begin
            bz = 1'b1;
            if (k <= lowEnd) begin
                cs = 1'b0;
                j  = k - 1 - D;
                if (j < 0) begin
                    m = 0;
                end else if (j < D * (2 * B - 1)) begin
                    m  = (j + D) / (2 * D);
                    sc = ((j / D) % 2 == 0);
                end else begin
                    m = B;
                end
                if (m < B) mo = cf[(m / W) * W + (W - 1 - m % W)];
            end else begin
                dn = (k == lowEnd + 1);
            end
        end
        return {cs, sc, mo, bz, dn};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mActive <= 1'b0;
        end else if (bus.start && !(mActive && (cyc - mT0) <= D * (2 + 2 * B))) begin
            mActive <= 1'b1;
            mT0     <= cyc;
            mCoeffs <= bus.coeffs;
            expQ.push_back(bus.coeffs);
        end
        cyc <= cyc + 1;
    end

    logic [4:0] e;
    logic prevCs = 1'b1, prevClk = 1'b0, prevMosi = 1'b0, prevBusy = 1'b0;
    int   mosiViol = 0;
    int   csFallQ[$], csRiseQ[$], doneQ[$], busyFallQ[$];

    always @(negedge clk) begin
        if (checkEn) begin
            e = expOut(mActive, cyc - mT0, mCoeffs);
            check("cs",     bus.cs,     e[4]);
            check("spiClk", bus.spiClk, e[3]);
            check("mosi",   bus.mosi,   e[2]);
            check("busy",   bus.busy,   e[1]);
            check("done",   bus.done,   e[0]);
            if (prevClk && bus.spiClk && !bus.cs && bus.mosi !== prevMosi) mosiViol++;
            if (prevCs && !bus.cs) csFallQ.push_back(cyc);
            if (!prevCs && bus.cs) csRiseQ.push_back(cyc);
            if (prevBusy && !bus.busy) busyFallQ.push_back(cyc);
            if (bus.done) doneQ.push_back(cyc);
        end
        prevCs   = bus.cs;
        prevClk  = bus.spiClk;
        prevMosi = bus.mosi;
        prevBusy = bus.busy;
    end

    // Mode-0 slave: capture on spiClk rise, deliver the word set when cs deasserts
    logic [B-1:0] rxBits = '0;
    logic [B-1:0] lastRxBits = '0;
    int           rxCount = 0, lastRxCount = 0, frames = 0, partial = 0;
    logic [B-1:0] ec;

    always @(posedge bus.spiClk or posedge bus.cs) begin
        if (bus.cs === 1'b1) begin
            if (rxCount > 0) begin
                lastRxBits  = rxBits;
                lastRxCount = rxCount;
                frames++;
                ec = (expQ.size() > 0) ? expQ.pop_front() : '0;
                if (rxCount == B) begin
                    for (int i = 0; i < N; i++)
                        check("rx_word", rxBits[B-1-i*W -: W], ec[i*W +: W]);
                end else begin
                    partial++;
                end
                rxCount = 0;
            end
        end else if (bus.cs === 1'b0) begin
            rxBits  = {rxBits[B-2:0], bus.mosi};
            rxCount = rxCount + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) step(1);
    endtask

    function automatic int qAt(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    typedef struct {
        logic [B-1:0] coeffs;
        logic [B-1:0] expBits;
    } vecT;
    vecT vecs[5];

    task automatic runVector(input vecT v);
        int t0, dn0, cf0, cr0, bf0, fr0;
        dn0 = doneQ.size(); cf0 = csFallQ.size(); cr0 = csRiseQ.size();
        bf0 = busyFallQ.size(); fr0 = frames;
        bus.coeffs = v.coeffs;
        bus.start  = 1'b1;
        t0 = cyc;
        step(1);
        bus.start = 1'b0;
        stepTo(t0 + 166);
        check("vec_done_count", doneQ.size() - dn0, 1);
        check("vec_done_cycle", qAt(doneQ, dn0) - t0, 163);
        check("vec_cs_fall",    qAt(csFallQ, cf0) - t0, 1);
        check("vec_cs_rise",    qAt(csRiseQ, cr0) - t0, 163);
        check("vec_busy_low",   qAt(busyFallQ, bf0) - t0, 165);
        check("vec_frames",     frames - fr0, 1);
        check("vec_edges",      lastRxCount, B);
        check("vec_bits",       lastRxBits, v.expBits);
    endtask

    initial begin
        int t0, t1, dn0, cf0, cr0, fr0, inWin;
        logic [63:0] r64;

        vecs[0] = '{40'h80_04_03_02_01, 40'h01_02_03_04_80};
        vecs[1] = '{40'hFF_00_A5_5A_C3, 40'hC3_5A_A5_00_FF};
        vecs[2] = '{40'h00_00_00_00_00, 40'h00_00_00_00_00};
        vecs[3] = '{40'h12_34_56_78_9A, 40'h9A_78_56_34_12};
        vecs[4] = '{40'hFF_FF_FF_FF_FF, 40'hFF_FF_FF_FF_FF};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.coeffs = '0;
        step(3);
        checkEn = 1'b1;
        check("rst_cs", bus.cs, 1'b1);
        check("rst_spiClk", bus.spiClk, 1'b0);
        check("rst_mosi", bus.mosi, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        reset = 1'b0;
        step(20);

        for (int i = 0; i < 5; i++) runVector(vecs[i]);

        // starts during a frame are dropped and late coeff changes do not leak in
        dn0 = doneQ.size(); fr0 = frames;
        bus.coeffs = vecs[0].coeffs;
        bus.start  = 1'b1;
        t0 = cyc;
        step(1);
        bus.start = 1'b0;
        stepTo(t0 + 5);   bus.coeffs = '1;
        stepTo(t0 + 10);  bus.start = 1'b1; step(1); bus.start = 1'b0;
        stepTo(t0 + 100); bus.start = 1'b1; step(1); bus.start = 1'b0;
        stepTo(t0 + 170);
        check("busy_start_done_count", doneQ.size() - dn0, 1);
        check("busy_start_frames", frames - fr0, 1);
        check("busy_start_bits", lastRxBits, vecs[0].expBits);

        // start held high: back-to-back frames every D*(2+2B)+1 cycles
        dn0 = doneQ.size(); cf0 = csFallQ.size(); cr0 = csRiseQ.size();
        bus.coeffs = vecs[3].coeffs;
        bus.start  = 1'b1;
        t0 = cyc;
        stepTo(t0 + 400);
        bus.start = 1'b0;
        inWin = 0;
        for (int i = dn0; i < doneQ.size(); i++) if (doneQ[i] < t0 + 400) inWin++;
        check("b2b_done_count", inWin, 2);
        check("b2b_first_cs", qAt(csFallQ, cf0) - t0, 1);
        check("b2b_second_cs", qAt(csFallQ, cf0 + 1) - t0, 166);
        check("b2b_cs_high_len", qAt(csFallQ, cf0 + 1) - qAt(csRiseQ, cr0), D + 1);
        stepTo(t0 + 500);

        // reset mid-frame abandons it; the next frame is whole
        dn0 = doneQ.size(); fr0 = frames;
        bus.coeffs = vecs[1].coeffs;
        bus.start  = 1'b1;
        t0 = cyc;
        step(1);
        bus.start = 1'b0;
        stepTo(t0 + 50);
        reset = 1'b1;
        step(1);
        check("rst_mid_cs", bus.cs, 1'b1);
        check("rst_mid_spiClk", bus.spiClk, 1'b0);
        check("rst_mid_busy", bus.busy, 1'b0);
        check("rst_mid_done", bus.done, 1'b0);
        check("rst_mid_partial_edges", lastRxCount, 12);
        reset = 1'b0;
        stepTo(t0 + 60);
        bus.coeffs = vecs[3].coeffs;
        bus.start  = 1'b1;
        t1 = cyc;
        step(1);
        bus.start = 1'b0;
        stepTo(t1 + 166);
        check("rst_mid_done_count", doneQ.size() - dn0, 1);
        check("rst_mid_done_cycle", qAt(doneQ, dn0) - t1, 163);
        check("rst_mid_frames", frames - fr0, 2);
        check("rst_mid_bits", lastRxBits, vecs[3].expBits);

        // random coeffs, gaps and stray start pulses against the model
        for (int r = 0; r < 8; r++) begin
            step($urandom_range(0, 4));
            r64 = {$urandom, $urandom};
            bus.coeffs = r64[B-1:0];
            bus.start  = 1'b1;
            step(1);
            for (int c = 0; c < 170; c++) begin
                bus.start = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) begin
                    r64 = {$urandom, $urandom};
                    bus.coeffs = r64[B-1:0];
                end
                step(1);
            end
        end
        bus.start = 1'b0;
        step(180);

        check("mosi_stable_high", mosiViol, 0);
        check("partial_frames", partial, 1);
        check("frames_outstanding", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
